// File: rtl/lcd_driver.sv
// HD44780 16x2 sequencer: power-up wait, 6-command init, then endless 32-cell refresh.
// Every byte goes LOAD -> EHI -> ELO; data bytes are preceded by a 2-cycle FETCH of the upstream character.
module lcd_driver #(
    parameter int PWR_WAIT = 750000,
    parameter int EN_PULSE = 12,
    parameter int CMD_WAIT = 2000,
    parameter int CLR_WAIT = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refresh_en,
    input  logic [7:0] data,
    output logic [4:0] sel,
    output logic [7:0] lcd_db,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic       init_done,
    output logic       frame_done
);

    localparam int MAX_A    = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
    localparam int MAX_B    = (CMD_WAIT > EN_PULSE) ? CMD_WAIT : EN_PULSE;
    localparam int MAX_WAIT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW       = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    // Counter reload values are one less than the length: the zero cycle counts.
    localparam logic [CW-1:0] PWR_LD = CW'(PWR_WAIT - 1);
    localparam logic [CW-1:0] EN_LD  = CW'(EN_PULSE - 1);
    localparam logic [CW-1:0] CMD_LD = CW'(CMD_WAIT - 1);
    localparam logic [CW-1:0] CLR_LD = CW'(CLR_WAIT - 1);

    typedef enum logic [2:0] {
        S_PWR,
        S_FETCH,
        S_FWAIT,
        S_LOAD,
        S_EHI,
        S_ELO,
        S_IDLE
    } state_t;

    typedef enum logic [1:0] {
        PH_INIT,
        PH_CMD1,
        PH_DATA,
        PH_CMD2
    } phase_t;

    state_t        state;
    phase_t        phase;
    logic [CW-1:0] cnt;
    logic [2:0]    init_idx;

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: init_cmd = 8'h38;
            3'd3:             init_cmd = 8'h0C;
            3'd4:             init_cmd = 8'h01;
            default:          init_cmd = 8'h06;
        endcase
    endfunction

    assign lcd_rw = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_PWR;
            phase      <= PH_INIT;
            cnt        <= PWR_LD;
            init_idx   <= '0;
            sel        <= '0;
            lcd_db     <= '0;
            lcd_rs     <= 1'b0;
            lcd_e      <= 1'b0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_PWR: begin
                    if (cnt == '0) begin
                        state  <= S_LOAD;
                        lcd_db <= init_cmd(3'd0);
                        lcd_rs <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_FETCH: state <= S_FWAIT;

                // Upstream registers sel, so data for the new index is valid now.
                S_FWAIT: begin
                    state  <= S_LOAD;
                    lcd_db <= data;
                    lcd_rs <= 1'b1;
                end

                S_LOAD: begin
                    state <= S_EHI;
                    lcd_e <= 1'b1;
                    cnt   <= EN_LD;
                end

                S_EHI: begin
                    if (cnt == '0) begin
                        state <= S_ELO;
                        lcd_e <= 1'b0;
                        cnt   <= (!lcd_rs && lcd_db == 8'h01) ? CLR_LD : CMD_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_ELO: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        case (phase)
                            PH_INIT: begin
                                state  <= S_LOAD;
                                lcd_rs <= 1'b0;
                                if (init_idx == 3'd5) begin
                                    init_done <= 1'b1;
                                    phase     <= PH_CMD1;
                                    lcd_db    <= 8'h80;
                                end else begin
                                    init_idx <= init_idx + 3'd1;
                                    lcd_db   <= init_cmd(init_idx + 3'd1);
                                end
                            end
                            // sel wraps to 0 only here, after the line-1 address command.
                            PH_CMD1: begin
                                sel   <= '0;
                                phase <= PH_DATA;
                                state <= S_FETCH;
                            end
                            PH_CMD2: begin
                                sel   <= sel + 5'd1;
                                phase <= PH_DATA;
                                state <= S_FETCH;
                            end
                            default: begin
                                if (sel == 5'd15) begin
                                    phase  <= PH_CMD2;
                                    state  <= S_LOAD;
                                    lcd_db <= 8'hC0;
                                    lcd_rs <= 1'b0;
                                end else if (sel == 5'd31) begin
                                    frame_done <= 1'b1;
                                    phase      <= PH_CMD1;
                                    if (refresh_en) begin
                                        state  <= S_LOAD;
                                        lcd_db <= 8'h80;
                                        lcd_rs <= 1'b0;
                                    end else begin
                                        state <= S_IDLE;
                                    end
                                end else begin
                                    sel   <= sel + 5'd1;
                                    state <= S_FETCH;
                                end
                            end
                        endcase
                    end
                end

                S_IDLE: begin
                    if (refresh_en) begin
                        state  <= S_LOAD;
                        lcd_db <= 8'h80;
                        lcd_rs <= 1'b0;
                    end
                end

                default: state <= S_PWR;
            endcase
        end
    end

endmodule
